rst_seq: RTL and testbench
==========================

# rst_seq

Parametrised, clocked multi-channel reset sequencer for testbenches. It holds up to NUM_CH reset outputs, each with its own polarity, for a fixed number of cycles, then releases them either together or one after another in index order. A sequence starts at power-on and can be re-run on request for a selected subset of channels. It sits at the top of a bench, driving the resets of several DUT domains from one clock.

## Interface
- NUM_CH, 4: number of reset channels; must be at least 1.
- ACTIVE_HIGH, all ones, NUM_CH bits: per-channel polarity. Bit i = 1 means rst[i] asserts high.
- HOLD_CYCLES, 16: number of cycles all selected channels stay asserted before the first release; must be at least 1.
- STAGGER_CYCLES, 4: gap in cycles between successive channel releases in staggered mode; must be at least 1.
- POR_STAGGER, 1: release mode for the power-on sequence (1 = staggered, 0 = simultaneous).
- clk  input  1  sequencer clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  1  start a sequence; sampled only in IDLE.
- ch_mask  input  NUM_CH  channels to reset on req; latched together with req.
- stagger_en  input  1  release mode for a req sequence; latched together with req.
- rst  output  NUM_CH  reset outputs; the driven level follows ACTIVE_HIGH per bit.
- busy  output  1  a sequence is in progress.
- done  output  1  one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, HOLD, RELEASE.
- rst_n low, at any time, asynchronously forces the following:
  - every rst[i] to its asserted level (ACTIVE_HIGH[i]);
  - state HOLD, hold counter 0, latched mask all ones, latched stagger = POR_STAGGER;
  - busy = 1, done = 0.
- A reset in the middle of a sequence aborts it and restarts the power-on sequence.
- IDLE:
  - all rst outputs deasserted, busy = 0.
  - req = 1 with ch_mask nonzero: latch ch_mask and stagger_en, assert the masked channels, go to HOLD.
  - req = 1 with ch_mask = 0: ignored, no done pulse.
- HOLD: count HOLD_CYCLES edges, then release the first masked channel and enter RELEASE.
- RELEASE:
  - Staggered: release masked channels in ascending index order, one every STAGGER_CYCLES. Unmasked channels are skipped at no cycle cost; the next index is found by a next-set-bit search.
  - Simultaneous: all masked channels release on the same edge as the first release.
- Completion: on the edge that releases the last masked channel, go to IDLE, busy goes to 0 and done goes to 1 for exactly one cycle.
- req while busy: ignored and not queued.
- Unmasked channels stay deasserted for the whole of a req sequence.

## Timing
- Take edge 0 as the first rising clk edge with rst_n high (power-on), or the edge that samples req in IDLE.
- req response: masked rst bits assert and busy rises after edge 0, so they are visible in the next cycle.
- k-th released channel (k = 0..m-1, m = number of masked channels) deasserts after these edges:
  - staggered: edge HOLD_CYCLES + k*STAGGER_CYCLES;
  - simultaneous: edge HOLD_CYCLES for every channel.
- done is high during the cycle after the final release edge. busy falls on that same edge.
- Power-on: rst is asserted for HOLD_CYCLES full cycles after rst_n rises.
- Counter width is $clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1). The counter never wraps; it clears on each state entry and on each release.
- All outputs come straight from registers, with no combinational path from any input.

## Structure
- Package rst_pkg holds:
  - typedef enum rst_seq_state_e {IDLE, HOLD, RELEASE};
  - function next_ch(mask, from), which returns the lowest set index at or above from.
- No sub-module: the counter and the next-set-bit search are small enough to stay inline.
- Elaboration assertions check NUM_CH >= 1, HOLD_CYCLES >= 1 and STAGGER_CYCLES >= 1.

## Test plan
- Power-on with NUM_CH=4, HOLD=16, STAGGER=4, ACTIVE_HIGH=4'b0101:
  - rst = 4'b0101 while rst_n is low;
  - ch0–ch3 release at edges 16, 20, 24, 28;
  - done is high only in the cycle after edge 28.
- req with ch_mask=4'b1010 and stagger_en=1 in IDLE:
  - ch1 and ch3 assert after edge 0; ch0 and ch2 never move;
  - ch1 releases at edge 16, ch3 at edge 20, done follows edge 20.
- req with ch_mask=4'b1111 and stagger_en=0: all four release at edge 16; busy is high from edge 0 through edge 16.
- req pulsed at edge 10 of an active sequence: no effect on timing and no second done. A req with ch_mask=0 in IDLE leaves busy low.
- rst_n pulsed low at edge 22 of a staggered sequence:
  - all channels return to asserted asynchronously;
  - the power-on sequence restarts from the rising edge of rst_n;
  - done does not pulse for the aborted sequence.
- NUM_CH=1, HOLD=1, STAGGER=1: the channel releases at edge 1, done follows edge 1, and back-to-back req pulses each produce exactly one done.

Source files
------------

// File: rtl/rst_pkg.sv
// rst_pkg: shared types and helpers for the reset sequencer.
//   rst_seq_state_e : sequencer states (IDLE, HOLD, RELEASE)
//   MAX_CH          : widest channel mask the search helper accepts
//   next_ch()       : lowest set index of a mask at or above a start index
package rst_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } rst_seq_state_e;

  localparam int MAX_CH = 32;

  // Returns the lowest index i >= from with mask[i] set, or MAX_CH if
  // there is none. Scanning downwards leaves the lowest hit in r.
  function automatic int next_ch(input logic [MAX_CH-1:0] mask, input int from);
    int r;
    r = MAX_CH;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rst_seq.sv
// rst_seq: clocked multi-channel reset sequencer.
// Holds the selected reset channels asserted for HOLD_CYCLES edges, then
// releases them either together or one every STAGGER_CYCLES in index order.
// Runs once at power-on and again for each accepted req.
// Ports:
//   clk        in   sequencer clock
//   rst_n      in   asynchronous active-low reset; restarts the power-on sequence
//   req        in   start a sequence (sampled only in IDLE)
//   ch_mask    in   channels to reset on req (latched with req)
//   stagger_en in   1 = staggered release, 0 = simultaneous (latched with req)
//   rst        out  reset outputs, asserted level per bit is ACTIVE_HIGH[i]
//   busy       out  sequence in progress
//   done       out  one-cycle pulse after the final release
module rst_seq
  import rst_pkg::*;
#(
  parameter int              NUM_CH         = 4,
  parameter logic [NUM_CH-1:0] ACTIVE_HIGH  = '1,
  parameter int              HOLD_CYCLES    = 16,
  parameter int              STAGGER_CYCLES = 4,
  parameter bit              POR_STAGGER    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              stagger_en,
  output logic [NUM_CH-1:0] rst,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("rst_seq: NUM_CH must be at least 1");
  end
  if (NUM_CH > MAX_CH) begin : g_chk_max_ch
    $error("rst_seq: NUM_CH exceeds MAX_CH");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("rst_seq: HOLD_CYCLES must be at least 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_chk_stag
    $error("rst_seq: STAGGER_CYCLES must be at least 1");
  end

  rst_seq_state_e    r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_mask;
  logic              r_stag;
  logic [IDX_W-1:0]  r_idx;
  logic              r_por;
  logic [NUM_CH-1:0] r_rst;
  logic              r_busy;
  logic              r_done;

  logic [MAX_CH-1:0] w_mask_ext;
  int                w_cur;
  int                w_nxt;
  logic              w_nxt_ok;
  logic [NUM_CH-1:0] w_rel;
  logic              w_tick;
  logic              w_last;
  logic [NUM_CH-1:0] w_rst_rel;

  // Release bookkeeping. In HOLD the channel being released is the first
  // masked one; in RELEASE it is the index found on the previous release.
  always_comb begin
    w_mask_ext = MAX_CH'(r_mask);
    w_cur      = (r_state == HOLD) ? next_ch(w_mask_ext, 0) : int'(r_idx);
    w_nxt      = next_ch(w_mask_ext, w_cur + 1);
    w_nxt_ok   = (w_nxt < NUM_CH);
    w_rel      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_stag) w_rel[i] = (i == w_cur);
      else        w_rel[i] = 1'b1;
    end
    // Drive released bits to their inactive level, keep the rest.
    w_rst_rel  = (r_rst & ~w_rel) | (~ACTIVE_HIGH & w_rel);
    w_last     = !r_stag || !w_nxt_ok;
    w_tick     = 1'b0;
    case (r_state)
      HOLD:    w_tick = !r_por && (r_cnt == HOLD_LAST);
      RELEASE: w_tick = (r_cnt == STAG_LAST);
      default: w_tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_mask  <= '1;
      r_stag  <= POR_STAGGER;
      r_idx   <= '0;
      // The first edge after reset is the power-on edge 0, which plays the
      // role of the req-sampling edge and is not counted as a hold edge.
      r_por   <= 1'b1;
      r_rst   <= ACTIVE_HIGH;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req && (|ch_mask)) begin
            r_mask  <= ch_mask;
            r_stag  <= stagger_en;
            r_rst   <= ~ACTIVE_HIGH ^ ch_mask;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= HOLD;
          end
        end
        HOLD, RELEASE: begin
          if (r_state == HOLD && r_por) begin
            r_por <= 1'b0;
          end else if (w_tick) begin
            r_rst <= w_rst_rel;
            r_cnt <= '0;
            if (w_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= RELEASE;
              r_idx   <= IDX_W'(w_nxt);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rst  = r_rst;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: scoreboard bench for rst_seq.
// Instance A: 4 channels, ACTIVE_HIGH=0101, HOLD=16, STAGGER=4.
// Instance B: 1 channel, HOLD=1, STAGGER=1 (back-to-back requests).
module tb_rst_seq;

  typedef struct packed {
    logic [3:0] rst;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, req_a, stag_a;
  logic [3:0] mask_a, rst_a;
  logic       busy_a, done_a;

  logic       rst_n_b, req_b, stag_b;
  logic [0:0] mask_b, rst_b;
  logic       busy_b, done_b;

  int n_pass  = 0;
  int n_total = 0;
  exp_t q[$];

  rst_seq #(
    .NUM_CH(4), .ACTIVE_HIGH(4'b0101), .HOLD_CYCLES(16),
    .STAGGER_CYCLES(4), .POR_STAGGER(1'b1)
  ) u_a (
    .clk(clk), .rst_n(rst_n_a), .req(req_a), .ch_mask(mask_a),
    .stagger_en(stag_a), .rst(rst_a), .busy(busy_a), .done(done_a)
  );

  rst_seq #(
    .NUM_CH(1), .ACTIVE_HIGH(1'b1), .HOLD_CYCLES(1),
    .STAGGER_CYCLES(1), .POR_STAGGER(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_n_b), .req(req_b), .ch_mask(mask_b),
    .stagger_en(stag_b), .rst(rst_b), .busy(busy_b), .done(done_b)
  );

  // Expected outputs in the cycle after edge e of a sequence (e < 0 means
  // before edge 0 of a power-on sequence, i.e. still held in reset).
  function automatic exp_t model(input int n, input logic [3:0] ah,
                                 input logic [3:0] mask, input bit stag,
                                 input int h, input int s, input int e);
    exp_t x;
    int   k;
    int   last;
    int   rel;
    x.rst = ~ah;
    k     = 0;
    last  = h;
    for (int i = 0; i < n; i++) begin
      if (mask[i]) begin
        rel = stag ? h + k * s : h;
        k++;
        if (rel > last) last = rel;
        if (e < rel) x.rst[i] = ah[i];
      end
    end
    for (int i = n; i < 4; i++) x.rst[i] = 1'b0;
    x.busy = (e < last);
    x.done = (e == last);
    return x;
  endfunction

  task automatic push_a(input logic [3:0] mask, input bit stag, input int e0, input int e1);
    for (int e = e0; e <= e1; e++) q.push_back(model(4, 4'b0101, mask, stag, 16, 4, e));
  endtask

  task automatic push_b(input int e);
    q.push_back(model(1, 4'b0001, 4'b0001, 1'b1, 1, 1, e));
  endtask

  task automatic test_reset();
    exp_t x;
    push_a(4'b1111, 1'b1, -1, -1);
    push_a(4'b1111, 1'b1, -1, -1);
    repeat (2) begin
      @(negedge clk);
      x = q.pop_front();
      n_total++;
      if ({rst_a, busy_a, done_a} !== {x.rst, x.busy, x.done})
        $display("FAIL in_reset got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 rst_a, busy_a, done_a, x.rst, x.busy, x.done);
      else n_pass++;
    end
    rst_n_a = 1'b1;
    push_a(4'b1111, 1'b1, 0, 30);
    for (int e = 0; e <= 30; e++) begin
      @(negedge clk);
      x = q.pop_front();
      n_total++;
      if ({rst_a, busy_a, done_a} !== {x.rst, x.busy, x.done})
        $display("FAIL por e=%0d got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 e, rst_a, busy_a, done_a, x.rst, x.busy, x.done);
      else n_pass++;
    end
  endtask

  task automatic test_req_stagger();
    exp_t x;
    req_a = 1'b1; mask_a = 4'b1010; stag_a = 1'b1;
    push_a(4'b1010, 1'b1, 0, 22);
    for (int e = 0; e <= 22; e++) begin
      @(negedge clk);
      req_a = 1'b0;
      x = q.pop_front();
      n_total++;
      if ({rst_a, busy_a, done_a} !== {x.rst, x.busy, x.done})
        $display("FAIL stagger e=%0d got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 e, rst_a, busy_a, done_a, x.rst, x.busy, x.done);
      else n_pass++;
    end
  endtask

  task automatic test_req_simul();
    exp_t x;
    req_a = 1'b1; mask_a = 4'b1111; stag_a = 1'b0;
    push_a(4'b1111, 1'b0, 0, 18);
    for (int e = 0; e <= 18; e++) begin
      @(negedge clk);
      req_a = 1'b0;
      x = q.pop_front();
      n_total++;
      if ({rst_a, busy_a, done_a} !== {x.rst, x.busy, x.done})
        $display("FAIL simul e=%0d got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 e, rst_a, busy_a, done_a, x.rst, x.busy, x.done);
      else n_pass++;
    end
  endtask

  task automatic test_req_while_busy();
    exp_t x;
    int   dones;
    req_a = 1'b1; mask_a = 4'b1111; stag_a = 1'b1;
    push_a(4'b1111, 1'b1, 0, 31);
    dones = 0;
    for (int e = 0; e <= 31; e++) begin
      @(negedge clk);
      // A second request lands on edge 10 with a different mask and mode.
      if (e == 9) begin
        req_a = 1'b1; mask_a = 4'b0001; stag_a = 1'b0;
      end else begin
        req_a = 1'b0;
      end
      if (done_a === 1'b1) dones++;
      x = q.pop_front();
      n_total++;
      if ({rst_a, busy_a, done_a} !== {x.rst, x.busy, x.done})
        $display("FAIL busy_req e=%0d got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 e, rst_a, busy_a, done_a, x.rst, x.busy, x.done);
      else n_pass++;
    end
    n_total++;
    if (dones !== 1) $display("FAIL busy_req_dones got %0d want 1", dones);
    else n_pass++;
    // Zero-mask request in IDLE: nothing moves.
    req_a = 1'b1; mask_a = 4'b0000; stag_a = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(exp_t'{4'b1010, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x = q.pop_front();
      n_total++;
      if ({rst_a, busy_a, done_a} !== {x.rst, x.busy, x.done})
        $display("FAIL zero_mask c=%0d got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 i, rst_a, busy_a, done_a, x.rst, x.busy, x.done);
      else n_pass++;
    end
    req_a = 1'b0;
  endtask

  task automatic test_abort();
    exp_t x;
    req_a = 1'b1; mask_a = 4'b1111; stag_a = 1'b1;
    push_a(4'b1111, 1'b1, 0, 22);
    for (int e = 0; e <= 22; e++) begin
      @(negedge clk);
      req_a = 1'b0;
      x = q.pop_front();
      n_total++;
      if ({rst_a, busy_a, done_a} !== {x.rst, x.busy, x.done})
        $display("FAIL abort_pre e=%0d got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 e, rst_a, busy_a, done_a, x.rst, x.busy, x.done);
      else n_pass++;
    end
    // Reset drops between clock edges: outputs must follow without an edge.
    rst_n_a = 1'b0;
    push_a(4'b1111, 1'b1, -1, -1);
    #1;
    x = q.pop_front();
    n_total++;
    if ({rst_a, busy_a, done_a} !== {x.rst, x.busy, x.done})
      $display("FAIL abort_async got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
               rst_a, busy_a, done_a, x.rst, x.busy, x.done);
    else n_pass++;
    @(negedge clk);
    rst_n_a = 1'b1;
    push_a(4'b1111, 1'b1, 0, 30);
    for (int e = 0; e <= 30; e++) begin
      @(negedge clk);
      x = q.pop_front();
      n_total++;
      if ({rst_a, busy_a, done_a} !== {x.rst, x.busy, x.done})
        $display("FAIL abort_por e=%0d got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 e, rst_a, busy_a, done_a, x.rst, x.busy, x.done);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    int   dones;
    push_b(-1);
    @(negedge clk);
    x = q.pop_front();
    n_total++;
    if ({rst_b, busy_b, done_b} !== {x.rst[0], x.busy, x.done})
      $display("FAIL b_reset got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
               rst_b, busy_b, done_b, x.rst[0], x.busy, x.done);
    else n_pass++;
    rst_n_b = 1'b1;
    for (int e = 0; e <= 3; e++) push_b(e);
    for (int e = 0; e <= 3; e++) begin
      @(negedge clk);
      x = q.pop_front();
      n_total++;
      if ({rst_b, busy_b, done_b} !== {x.rst[0], x.busy, x.done})
        $display("FAIL b_por e=%0d got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 e, rst_b, busy_b, done_b, x.rst[0], x.busy, x.done);
      else n_pass++;
    end
    // req held high: each accepted request runs a two-edge sequence.
    req_b = 1'b1; mask_b = 1'b1; stag_b = 1'b1;
    for (int j = 0; j < 6; j++) push_b(j % 2);
    push_b(2);
    push_b(3);
    dones = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 5) req_b = 1'b0;
      if (done_b === 1'b1) dones++;
      x = q.pop_front();
      n_total++;
      if ({rst_b, busy_b, done_b} !== {x.rst[0], x.busy, x.done})
        $display("FAIL b2b c=%0d got rst=%b busy=%b done=%b want rst=%b busy=%b done=%b",
                 j, rst_b, busy_b, done_b, x.rst[0], x.busy, x.done);
      else n_pass++;
    end
    n_total++;
    if (dones !== 3) $display("FAIL b2b_dones got %0d want 3", dones);
    else n_pass++;
  endtask

  initial begin
    rst_n_a = 1'b0; req_a = 1'b0; mask_a = 4'b0000; stag_a = 1'b0;
    rst_n_b = 1'b0; req_b = 1'b0; mask_b = 1'b0;    stag_b = 1'b0;
    test_reset();
    test_req_stagger();
    test_req_simul();
    test_req_while_busy();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
